// File: rtl/fifo_pkg.sv
// Shared latency/depth helpers for the FIFO read-side stream adapter.
// Buffer depth is the effective read latency plus two entries so a full-rate stream survives the credit loop.
package fifo_pkg;

  localparam int MAX_READ_LATENCY = 3;

  function automatic int eff_lat(input int show_ahead, input int read_latency);
    return (show_ahead != 0) ? 0 : read_latency;
  endfunction

  function automatic int buf_depth(input int lat);
    return lat + 2;
  endfunction

endpackage

// File: rtl/stream_obuf.sv
// Circular flop buffer with head/tail pointers; push and pop may coincide, clr_i empties it in one cycle.
// Head data comes straight from flops; the caller never pops when empty nor pushes when full.
module stream_obuf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 3,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_dat_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_dat_o,
  output logic [CNT_W-1:0]      cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) tail_d = ptr_inc(tail_q);
      if (pop_i)  head_d = ptr_inc(head_q);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload needs no reset: cnt_q gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[tail_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[head_q];
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync FIFO into a valid/ready stream; first word valid EFF_LAT+1 cycles after its pop.
// Pops are credit-limited by registered occupancy only, so m_ready_i never reaches fifo_pop_o.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int SHOW_AHEAD   = 0,
  localparam int EFF_LAT     = eff_lat(SHOW_AHEAD, READ_LATENCY),
  localparam int BUF_DEPTH   = buf_depth(EFF_LAT),
  localparam int OCC_W       = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [OCC_W-1:0]      occupancy_o
);

  logic             ret_vld;
  logic             consume;
  logic [OCC_W-1:0] buf_cnt;
  logic [OCC_W-1:0] inflight_cnt;
  logic [OCC_W-1:0] occ;

  assign occ         = buf_cnt + inflight_cnt;
  assign fifo_pop_o  = ~rst_i & ~flush_i & ~fifo_empty_i & (occ < OCC_W'(BUF_DEPTH));
  assign m_valid_o   = (buf_cnt != '0);
  assign consume     = m_valid_o & m_ready_i;
  assign occupancy_o = occ;

  if (EFF_LAT == 0) begin : g_lat0
    assign ret_vld      = fifo_pop_o;
    assign inflight_cnt = '0;
  end else begin : g_pipe
    logic [EFF_LAT-1:0] pipe_q, pipe_d;

    // One valid bit per outstanding read; the MSB marks the word landing on fifo_data_i now.
    always_comb begin
      pipe_d = (pipe_q << 1) | EFF_LAT'(fifo_pop_o);
      if (flush_i) pipe_d = '0;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) pipe_q <= '0;
      else       pipe_q <= pipe_d;
    end

    assign ret_vld = pipe_q[EFF_LAT-1];

    always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < EFF_LAT; i++) inflight_cnt = inflight_cnt + OCC_W'(pipe_q[i]);
    end
  end

  stream_obuf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (BUF_DEPTH)
  ) u_obuf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (flush_i),
    .push_i    (ret_vld),
    .push_dat_i(fifo_data_i),
    .pop_i     (consume),
    .head_dat_o(m_data_o),
    .cnt_o     (buf_cnt)
  );

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side adapter that drains a synchronous FIFO and presents its contents as a valid/ready stream.
- Drives the FIFO pop and absorbs the FIFO's RAM read latency with a credit-limited output buffer.
- Sustains one word per cycle with no combinational path from m_ready_i to fifo_pop_o.
- Sits between any sync FIFO instance and a downstream stream consumer.

Parameters:
- DATA_WIDTH, 32: word width.
- READ_LATENCY, 1: cycles from fifo_pop_o to valid fifo_data_i when SHOW_AHEAD=0; legal range 0..3.
- SHOW_AHEAD, 0: 1 = fifo_data_i is valid whenever fifo_empty_i=0 and is captured in the pop cycle (effective latency 0).
- BUF_DEPTH, derived, EFF_LAT+2 where EFF_LAT = SHOW_AHEAD ? 0 : READ_LATENCY: output buffer entries.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is synchronous and active-high.
- fifo_empty_i  in  1  FIFO registered empty flag.
- fifo_data_i  in  DATA_WIDTH  FIFO read data.
- fifo_pop_o  out  1  FIFO pop strobe.
- flush_i  in  1  discard buffered and in-flight words.
- m_data_o  out  DATA_WIDTH  stream data.
- m_valid_o  out  1  stream valid.
- m_ready_i  in  1  stream ready.
- occupancy_o  out  $clog2(BUF_DEPTH+1)  buffered count plus in-flight count.

Behaviour:
- Reset (rst_i=1 at a clock edge): m_valid_o=0, occupancy_o=0, buffer pointers=0, in-flight pipe cleared. fifo_pop_o is forced to 0 while rst_i=1. m_data_o is don't-care.
- Occupancy: occ = buf_cnt + inflight_cnt, both registered.
- Pop rule: fifo_pop_o = ~rst_i & ~flush_i & ~fifo_empty_i & (occ < BUF_DEPTH).
  - Depends on registered state only; m_ready_i never enters this term.
  - fifo_empty_i reflects the FIFO count after the previous cycle's pop, so back-to-back pops are legal.
- In-flight pipe:
  - Shift register of EFF_LAT valid bits; bit 0 is set on fifo_pop_o.
  - The word returns at the cycle when the valid bit exits the pipe. With EFF_LAT=0 the word returns in the pop cycle itself.
  - The returning word is written to the buffer tail at that edge.
- Output buffer: circular flop array of BUF_DEPTH entries with head/tail pointers. Pointers wrap from BUF_DEPTH-1 to 0.
- Stream outputs:
  - m_valid_o = (buf_cnt != 0).
  - m_data_o = entry[head], taken from flops only; no combinational path from fifo_data_i.
  - Consume on m_valid_o & m_ready_i: head advances, buf_cnt decrements.
- Simultaneous write and consume: buf_cnt unchanged, head and tail both advance. At buf_cnt=1 the new word becomes visible the next cycle.
- Overflow cannot occur by construction; the credit check guarantees occ <= BUF_DEPTH. The bench asserts this.
- Latency: FIFO going non-empty at cycle t gives pop at t and m_valid_o=1 at t+EFF_LAT+1.
- Throughput: with m_ready_i tied high and the FIFO non-empty, one word per cycle in steady state.
- Stall: m_ready_i=0 lets occ fill to BUF_DEPTH, after which pops stop. m_data_o and m_valid_o hold stable while stalled.
- flush_i=1 at an edge:
  - buf_cnt=0 and pointers reset.
  - In-flight valid bits cleared, so late-returning words are dropped.
  - No pop is issued in the flush cycle.
  - FIFO contents are untouched.
  - Normal operation resumes the next cycle.
- Reset mid-operation behaves identically to flush and also clears state.
- Word order is preserved exactly; no duplication or loss except by flush or reset.

Decomposition:
- Shared package fifo_pkg holds:
  - function eff_lat(show_ahead, read_latency);
  - function buf_depth(eff_lat);
  - localparam MAX_READ_LATENCY = 3.
- One natural sub-module, stream_obuf: the circular flop buffer with push/pop/count, parameterised by DATA_WIDTH and DEPTH, synchronous active-high reset.
- Credit and pop logic and the in-flight pipe stay in fifo_stream_reader.

Test Plan:
- Streaming: READ_LATENCY=1, SHOW_AHEAD=0, FIFO preloaded 0x1..0x10, m_ready_i=1 → first m_valid_o 2 cycles after first pop; 16 words 0x1..0x10 in order on 16 consecutive cycles.
- Stall: READ_LATENCY=2, 8 words, m_ready_i=0 → fifo_pop_o stops after exactly 4 pops, occupancy_o=4, m_data_o=0x1 stable. Release m_ready_i → all 8 words delivered in order.
- Show-ahead: SHOW_AHEAD=1, single word 0xA5 → pop and capture in the same cycle; m_valid_o next cycle with m_data_o=0xA5; FIFO then empty, no further pops.
- Random backpressure: 50% random m_ready_i, 1000 random words, READ_LATENCY=3 → scoreboard exact order; occ <= 5 every cycle; no pop while fifo_empty_i=1.
- Flush: assert flush_i with 2 words in flight and 3 buffered → next cycle m_valid_o=0, occupancy_o=0. The in-flight words are never emitted, and the next delivered word is the FIFO's next entry.
- Reset: rst_i pulsed mid-stream → during reset fifo_pop_o=0; after release m_valid_o=0 and occupancy_o=0, and streaming resumes cleanly.
